// File: rtl/rv32i_types.sv
// Shared issue-queue types: slot entry layout and tag/payload widths.
// Feature macro affecting users of this package: ISSUE_AGE_PRIORITY_EN.
package rv32i_types;

  localparam int IQ_TAG_W     = 6;
  localparam int IQ_PAYLOAD_W = 64;

  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0] payload;
    logic [IQ_TAG_W-1:0]     ps1;
    logic [IQ_TAG_W-1:0]     ps2;
    logic                    rdy1;
    logic                    rdy2;
  } iq_entry_t;

  function automatic logic tag_hit(
    input logic                v,
    input logic [IQ_TAG_W-1:0] a,
    input logic [IQ_TAG_W-1:0] b
  );
    return v && (a == b);
  endfunction

endpackage

// File: rtl/issue_select_arbiter.sv
// Picks one eligible slot: lowest index, or oldest when
// ISSUE_AGE_PRIORITY_EN is defined (older_i[j][i]=1: j older than i).
module issue_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]          elig_i,
`ifdef ISSUE_AGE_PRIORITY_EN
  input  logic [N-1:0][N-1:0]   older_i,
`endif
  output logic                  found_o,
  output logic [IDX_W-1:0]      idx_o
);

  logic [N-1:0] win;

`ifdef ISSUE_AGE_PRIORITY_EN
  // A slot wins only if no eligible slot is older than it
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      win[i] = elig_i[i];
      for (int j = 0; j < N; j++) begin
        if (elig_i[j] && older_i[j][i]) win[i] = 1'b0;
      end
    end
  end
`else
  // Every eligible slot competes on index alone
  always_comb begin
    win = elig_i;
  end
`endif

  // Lowest-index winner
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (win[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// Issue-queue read side: slot state, CDB wakeup, select and offer lock.
// Age-ordered selection is enabled by defining ISSUE_AGE_PRIORITY_EN.
import rv32i_types::*;

module issue_select #(
  parameter int QUEUE_DEPTH = 3,
  parameter int PAYLOAD_W   = IQ_PAYLOAD_W,
  parameter int TAG_W       = IQ_TAG_W,
  localparam int IDX_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   disp_valid,
  input  logic [IDX_W-1:0]       disp_addr,
  input  logic [PAYLOAD_W-1:0]   disp_payload,
  input  logic [TAG_W-1:0]       disp_ps1,
  input  logic [TAG_W-1:0]       disp_ps2,
  input  logic                   disp_ps1_rdy,
  input  logic                   disp_ps2_rdy,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_pd,
  output logic [QUEUE_DEPTH-1:0] valid_vect,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [PAYLOAD_W-1:0]   issue_payload,
  output logic [IDX_W-1:0]       issue_slot
);

  logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
  iq_entry_t              ent_q [QUEUE_DEPTH];
  iq_entry_t              ent_d [QUEUE_DEPTH];
  logic                   lock_q, lock_d;
  logic [IDX_W-1:0]       lock_slot_q, lock_slot_d;

  logic [QUEUE_DEPTH-1:0] elig, disp_oh, fire_oh;
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx, sel;
  logic                   lock_live, offer, fire;
  logic                   disp_busy, disp_ok;

`ifdef ISSUE_AGE_PRIORITY_EN
  logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] older_q, older_d;
`endif

  // Eligibility and dispatch target decode
  always_comb begin
    elig    = '0;
    disp_oh = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      elig[i]    = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
      disp_oh[i] = (disp_addr == IDX_W'(i));
    end
    disp_busy = |(disp_oh & valid_q);
    disp_ok   = disp_valid & ~disp_busy & (|disp_oh);
  end

  issue_arbiter #(
    .N     (QUEUE_DEPTH),
    .IDX_W (IDX_W)
  ) u_arb (
    .elig_i  (elig),
`ifdef ISSUE_AGE_PRIORITY_EN
    .older_i (older_q),
`endif
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Offer: locked slot wins over the arbiter
  always_comb begin
    sel       = lock_q ? lock_slot_q : arb_idx;
    lock_live = 1'b0;
    fire_oh   = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (lock_slot_q == IDX_W'(i)) lock_live = valid_q[i];
    end
    offer         = lock_q ? lock_live : arb_found;
    fire          = offer & issue_ready;
    issue_valid   = offer;
    issue_slot    = offer ? sel : '0;
    issue_payload = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (offer && sel == IDX_W'(i)) issue_payload = ent_q[i].payload;
      fire_oh[i] = fire && (sel == IDX_W'(i));
    end
    valid_vect = valid_q;
  end

  // Slot next state: wakeup, retire, dispatch, flush
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (valid_q[i]) begin
        if (tag_hit(cdb_valid, cdb_pd, ent_q[i].ps1)) ent_d[i].rdy1 = 1'b1;
        if (tag_hit(cdb_valid, cdb_pd, ent_q[i].ps2)) ent_d[i].rdy2 = 1'b1;
      end
      if (fire_oh[i]) valid_d[i] = 1'b0;
      if (disp_ok && disp_oh[i]) begin
        ent_d[i].payload = disp_payload;
        ent_d[i].ps1     = disp_ps1;
        ent_d[i].ps2     = disp_ps2;
        ent_d[i].rdy1    = disp_ps1_rdy | tag_hit(cdb_valid, cdb_pd, disp_ps1);
        ent_d[i].rdy2    = disp_ps2_rdy | tag_hit(cdb_valid, cdb_pd, disp_ps2);
        valid_d[i]       = 1'b1;
      end
      if (flush) valid_d[i] = 1'b0;
    end
  end

  // Lock holds a stalled offer until it fires
  always_comb begin
    lock_d      = lock_q;
    lock_slot_d = lock_slot_q;
    if (flush || fire || !offer) begin
      lock_d = 1'b0;
    end else if (!issue_ready) begin
      lock_d      = 1'b1;
      lock_slot_d = sel;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

`ifdef ISSUE_AGE_PRIORITY_EN
  // New entry is younger than every occupied slot
  always_comb begin
    older_d = older_q;
    if (flush) begin
      older_d = '0;
    end else if (disp_ok) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        if (disp_oh[k]) begin
          for (int j = 0; j < QUEUE_DEPTH; j++) older_d[j][k] = valid_q[j];
          older_d[k] = '0;
        end
      end
    end
  end

  // Age matrix register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) older_q <= '0;
    else        older_q <= older_d;
  end
`endif

  disp_to_busy_slot_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(disp_valid && !flush && disp_busy)
  );

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: dispatch, wakeup, lock, flush, reset.
// Expected order in the age test depends on ISSUE_AGE_PRIORITY_EN.
module tb_issue_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic [1:0]  disp_addr;
  logic [63:0] disp_payload;
  logic [5:0]  disp_ps1, disp_ps2;
  logic        disp_ps1_rdy, disp_ps2_rdy;
  logic        cdb_valid;
  logic [5:0]  cdb_pd;
  logic [2:0]  valid_vect;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_payload;
  logic [1:0]  issue_slot;

  int errors = 0;
  int checks = 0;

  issue_select dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_addr     (disp_addr),
    .disp_payload  (disp_payload),
    .disp_ps1      (disp_ps1),
    .disp_ps2      (disp_ps2),
    .disp_ps1_rdy  (disp_ps1_rdy),
    .disp_ps2_rdy  (disp_ps2_rdy),
    .cdb_valid     (cdb_valid),
    .cdb_pd        (cdb_pd),
    .valid_vect    (valid_vect),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_payload (issue_payload),
    .issue_slot    (issue_slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [1:0] a, input logic [63:0] p,
                      input logic [5:0] t1, input logic r1,
                      input logic [5:0] t2, input logic r2);
    disp_valid   = 1'b1;
    disp_addr    = a;
    disp_payload = p;
    disp_ps1     = t1;
    disp_ps1_rdy = r1;
    disp_ps2     = t2;
    disp_ps2_rdy = r2;
  endtask

  task automatic cdb(input logic v, input logic [5:0] t);
    cdb_valid = v;
    cdb_pd    = t;
  endtask

  logic [1:0] first_slot, second_slot;

  initial begin
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_addr = '0;
    disp_payload = '0; disp_ps1 = '0; disp_ps2 = '0;
    disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
    cdb_valid = 1'b0; cdb_pd = '0; issue_ready = 1'b0;
`ifdef ISSUE_AGE_PRIORITY_EN
    first_slot = 2'd2; second_slot = 2'd0;
`else
    first_slot = 2'd0; second_slot = 2'd2;
`endif
    #3;
    chk("rst_vv", 64'(valid_vect), 64'd0);
    chk("rst_iv", 64'(issue_valid), 64'd0);
    chk("rst_slot", 64'(issue_slot), 64'd0);
    chk("rst_pay", issue_payload, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ready dispatch, offered next cycle, fires, freed after
    disp(2'd0, 64'hA0A0, 6'd1, 1'b1, 6'd2, 1'b1);
    issue_ready = 1'b1;
    #1 chk("disp_no_bypass_offer", 64'(issue_valid), 64'd0);
    tick();
    disp_valid = 1'b0;
    #1 chk("d1_iv", 64'(issue_valid), 64'd1);
    chk("d1_slot", 64'(issue_slot), 64'd0);
    chk("d1_pay", issue_payload, 64'hA0A0);
    chk("d1_vv", 64'(valid_vect), 64'b001);
    tick();
    chk("d1_freed_vv", 64'(valid_vect), 64'b000);
    chk("d1_freed_iv", 64'(issue_valid), 64'd0);

    // wakeup via CDB
    disp(2'd1, 64'hB1B1, 6'd5, 1'b0, 6'd6, 1'b1);
    tick();
    disp_valid = 1'b0;
    #1 chk("wk_wait_iv", 64'(issue_valid), 64'd0);
    chk("wk_vv", 64'(valid_vect), 64'b010);
    cdb(1'b1, 6'd5);
    #1 chk("wk_cdb_cycle_iv", 64'(issue_valid), 64'd0);
    tick();
    cdb(1'b0, 6'd0);
    #1 chk("wk_iv", 64'(issue_valid), 64'd1);
    chk("wk_slot", 64'(issue_slot), 64'd1);
    chk("wk_pay", issue_payload, 64'hB1B1);
    tick();
    chk("wk_freed_vv", 64'(valid_vect), 64'b000);

    // same-cycle bypass on dispatch
    disp(2'd2, 64'hC2C2, 6'd7, 1'b0, 6'd9, 1'b1);
    cdb(1'b1, 6'd7);
    tick();
    disp_valid = 1'b0;
    cdb(1'b0, 6'd0);
    #1 chk("byp_iv", 64'(issue_valid), 64'd1);
    chk("byp_slot", 64'(issue_slot), 64'd2);
    chk("byp_pay", issue_payload, 64'hC2C2);
    tick();
    chk("byp_freed_vv", 64'(valid_vect), 64'b000);

    // lock: slot 2 stalled, slot 0 wakes, offer must not move
    issue_ready = 1'b0;
    disp(2'd0, 64'hE0E0, 6'd3, 1'b0, 6'd2, 1'b1);
    cdb(1'b1, 6'd4);
    tick();
    cdb(1'b0, 6'd0);
    disp(2'd2, 64'hD2D2, 6'd1, 1'b1, 6'd1, 1'b1);
    #1 chk("wrong_tag_iv", 64'(issue_valid), 64'd0);
    tick();
    disp_valid = 1'b0;
    #1 chk("lk_iv", 64'(issue_valid), 64'd1);
    chk("lk_slot", 64'(issue_slot), 64'd2);
    cdb(1'b1, 6'd3);
    tick();
    cdb(1'b0, 6'd0);
    #1 chk("lk_hold_slot", 64'(issue_slot), 64'd2);
    chk("lk_hold_pay", issue_payload, 64'hD2D2);
    chk("lk_vv", 64'(valid_vect), 64'b101);
    tick();
    chk("lk_hold2_slot", 64'(issue_slot), 64'd2);
    issue_ready = 1'b1;
    tick();
    chk("lk_next_slot", 64'(issue_slot), 64'd0);
    chk("lk_next_pay", issue_payload, 64'hE0E0);
    chk("lk_next_vv", 64'(valid_vect), 64'b001);
    tick();
    chk("lk_done_vv", 64'(valid_vect), 64'b000);
    chk("lk_done_iv", 64'(issue_valid), 64'd0);

    // priority: slot 2 dispatched before slot 0, both woken together
    issue_ready = 1'b0;
    disp(2'd2, 64'hF2F2, 6'd8, 1'b0, 6'd1, 1'b1);
    tick();
    disp(2'd0, 64'hF0F0, 6'd8, 1'b0, 6'd1, 1'b1);
    tick();
    disp_valid = 1'b0;
    cdb(1'b1, 6'd8);
    #1 chk("pr_wait_iv", 64'(issue_valid), 64'd0);
    tick();
    cdb(1'b0, 6'd0);
    #1 chk("pr_first_slot", 64'(issue_slot), 64'(first_slot));
    issue_ready = 1'b1;
    tick();
    chk("pr_second_slot", 64'(issue_slot), 64'(second_slot));
    chk("pr_second_iv", 64'(issue_valid), 64'd1);
    tick();
    chk("pr_done_vv", 64'(valid_vect), 64'b000);

    // flush with pending offer, fire and dispatch in the same cycle
    issue_ready = 1'b0;
    disp(2'd0, 64'h1000, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    disp(2'd1, 64'h1001, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    disp(2'd2, 64'h1002, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    disp_valid = 1'b0;
    #1 chk("fl_pre_vv", 64'(valid_vect), 64'b111);
    chk("fl_pre_slot", 64'(issue_slot), 64'd0);
    flush = 1'b1;
    issue_ready = 1'b1;
    disp(2'd1, 64'h2001, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    issue_ready = 1'b0;
    #1 chk("fl_vv", 64'(valid_vect), 64'b000);
    chk("fl_iv", 64'(issue_valid), 64'd0);
    disp(2'd1, 64'h3001, 6'd1, 1'b1, 6'd1, 1'b1);
    tick();
    disp_valid = 1'b0;
    #1 chk("fl_after_slot", 64'(issue_slot), 64'd1);
    chk("fl_after_pay", issue_payload, 64'h3001);

    // async reset mid-handshake drops the offer at once
    #1 rst_n = 1'b0;
    #1 chk("ar_iv", 64'(issue_valid), 64'd0);
    chk("ar_vv", 64'(valid_vect), 64'b000);
    chk("ar_pay", issue_payload, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_post_iv", 64'(issue_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_select.md
# issue_select

Read side of the issue queue: holds per-slot valid/ready state for up to QUEUE_DEPTH entries, wakes source operands on CDB broadcast, and selects one ready entry per cycle for the functional unit over a valid/ready handshake. Dispatch writes a free slot chosen by the free-slot picker, which consumes `valid_vect` from this block. Issue retires the slot.

## Interface
- QUEUE_DEPTH, 3: number of slots; need not be a power of two.
- PAYLOAD_W, 64: opaque µop payload width.
- TAG_W, 6: physical register tag width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all slots.
- disp_valid  in  1  write request from dispatch/rename.
- disp_addr  in  $clog2(QUEUE_DEPTH)  target slot; must be a free slot.
- disp_payload  in  PAYLOAD_W  µop payload.
- disp_ps1 / disp_ps2  in  TAG_W each  source tags.
- disp_ps1_rdy / disp_ps2_rdy  in  1 each  source already available.
- cdb_valid  in  1  wakeup broadcast valid.
- cdb_pd  in  TAG_W  tag being broadcast.
- valid_vect  out  QUEUE_DEPTH  registered slot occupancy.
- issue_valid  out  1  an entry is offered to the FU.
- issue_ready  in  1  FU accepts this cycle.
- issue_payload  out  PAYLOAD_W  payload of the offered entry.
- issue_slot  out  $clog2(QUEUE_DEPTH)  index of the offered entry.

## Operation
- Per-slot state: valid, payload, ps1/ps2 tags, rdy1/rdy2.
- Dispatch: when disp_valid, slot disp_addr is loaded and valid is set at the next edge.
  - rdyN = disp_psN_rdy OR (cdb_valid AND cdb_pd == disp_psN), giving a same-cycle wakeup bypass.
- Dispatch to a slot that is already valid is illegal. The write is dropped, and a simulation assertion fires.
- Wakeup: for each valid slot, a source whose tag equals cdb_pd while cdb_valid sets its rdy at the next edge.
- Eligible = valid AND rdy1 AND rdy2.
- Selection: lowest-index eligible slot (see Configuration).
- Lock: when issue_valid=1 and issue_ready=0, the selected slot is latched. The offer then stays stable (same slot and payload) until it is accepted, even if another slot becomes eligible.
- Fire = issue_valid AND issue_ready. On fire, the slot's valid clears at the next edge and the lock releases.
- Flush clears all valid bits and the lock at the next edge. It takes priority over dispatch and fire in the same cycle.

## Timing
- Reset (async, rst_n=0): valid_vect=0, issue_valid=0, issue_slot=0, issue_payload=0, lock cleared, all rdy=0.
- issue_valid, issue_slot and issue_payload are combinational from registered state plus the lock.
- Dispatch latency:
  - An entry dispatched with both sources ready is offered in cycle N+1.
  - An entry woken by CDB in cycle N is offered in N+1.
- Back-to-back fire is allowed every cycle. A slot freed by fire in cycle N shows as free in valid_vect at N+1.
- Dispatch and fire may occur in the same cycle to different slots.
- issue_ready is ignored while issue_valid=0.
- Reset asserted mid-handshake drops the offer immediately.

## Configuration
- ISSUE_AGE_PRIORITY_EN defined:
  - An age matrix older[i][j] is kept.
  - On dispatch to slot k: older[j][k]=1 for every valid j, and older[k][*]=0.
  - Selection picks the eligible slot with no eligible older slot.
  - Flush and reset clear the matrix.
- Undefined: fixed lowest-index priority, with no age storage.
- Lock and handshake behaviour are identical in both builds.

## Structure
- rv32i_types holds `iq_entry_t` (payload, tags, rdy bits) and the tag-width constant.
- Sub-module `issue_arbiter`: combinational select of one eligible index from an eligibility vector. In the age build it also takes the age matrix. It returns a found flag and the index.
- Lock register, wakeup comparators and slot storage live in `issue_select`.

## Test plan
- Reset, then dispatch slot 0 with ps1_rdy=1 and ps2_rdy=1 in cycle 1, issue_ready=1 -> issue_valid=1, issue_slot=0 in cycle 2; valid_vect=000 in cycle 3.
- Dispatch slot 1 with ps1=5 not ready, ps2 ready -> no offer. Then cdb_valid with cdb_pd=5 in cycle 4 -> offered in cycle 5.
- Same-cycle bypass: dispatch ps1=7 not ready while cdb_pd=7 -> offered in the next cycle.
- Lock:
  - Setup: slot 2 offered with issue_ready=0, then slot 0 becomes eligible.
  - Required: issue_slot stays 2 until fire, then moves to 0.
- Age build: dispatch slot 2, then slot 0, both ready -> slot 2 is issued first. Without the macro -> slot 0 first.
- Flush while slots 0–2 are valid and an offer is pending, with a concurrent dispatch -> valid_vect=000 and issue_valid=0 next cycle.
